windowed_accumulator: RTL
=========================

WINDOWED_ACCUMULATOR -- requirements
Module: windowed_accumulator

Interface
REQ-001 Parameter WIDTH, default 8: accumulator and sum output width in bits, WIDTH >= 2.
REQ-002 Parameter IN_WIDTH, default 8: input operand width in bits, 1 <= IN_WIDTH <= WIDTH.
REQ-003 Parameter DEPTH, default 2: accumulations per window, DEPTH >= 1.
REQ-004 Parameter SATURATE, default 0: 0 wraps modulo 2^WIDTH, 1 clamps at 2^WIDTH-1.
REQ-005 Parameter EMIT_ZERO, default 1: 1 emits a zero sum at the start of every window, 0 suppresses it.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 clear  input  1  synchronous window abort and restart, active-high.
REQ-009 in_data  input  IN_WIDTH  unsigned operand.
REQ-010 in_valid  input  1  operand offered.
REQ-011 in_ready  output  1  block can accept an operand.
REQ-012 sum_data  output  WIDTH  running sum.
REQ-013 sum_valid  output  1  sum_data, sum_last and sum_ovf are valid.
REQ-014 sum_ready  input  1  consumer accepts the sum.
REQ-015 sum_last  output  1  the sum is the final one of its window.
REQ-016 sum_ovf  output  1  overflow occurred in the current window, sticky.

Function
REQ-017 The FSM SHALL have exactly three states: EMIT_INIT, WAIT_IN and EMIT.
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when sum_valid && sum_ready.
REQ-019 in_ready SHALL equal (state == WAIT_IN) && !clear.
REQ-020 sum_valid SHALL be 1 exactly in states EMIT_INIT and EMIT.
REQ-021 EMIT_INIT SHALL present sum_data=0, sum_last=0, sum_ovf=0, and SHALL go to WAIT_IN on an output transfer.
REQ-022 WAIT_IN SHALL go to EMIT on an input transfer and SHALL update sum and count in the same edge.
REQ-023 The input-to-sum latency SHALL be 1 cycle: an input accepted at edge t makes sum_valid=1 after edge t.
REQ-024 Addition SHALL zero-extend in_data to WIDTH+1 bits; a carry out of bit WIDTH-1 is an overflow.
REQ-025 On overflow, sum SHALL become (sum+in) mod 2^WIDTH when SATURATE=0, or 2^WIDTH-1 when SATURATE=1.
REQ-026 With SATURATE=1, an already-saturated sum plus any nonzero input SHALL stay at 2^WIDTH-1 and SHALL set sum_ovf; adding 0 SHALL NOT set sum_ovf.
REQ-027 sum_ovf SHALL set on any overflow in the window and stay set until the window ends.
REQ-028 The accumulation counter SHALL be $clog2(DEPTH+1) bits wide, SHALL increment on each input transfer, and sum_last SHALL be 1 in EMIT when count == DEPTH.
REQ-029 In EMIT, an output transfer with count < DEPTH SHALL return to WAIT_IN.
REQ-030 In EMIT, an output transfer with count == DEPTH SHALL zero sum, count and sum_ovf, then go to EMIT_INIT if EMIT_ZERO=1 or to WAIT_IN if EMIT_ZERO=0.
REQ-031 While sum_valid=1 and sum_ready=0, sum_data, sum_last and sum_ovf SHALL hold stable.
REQ-032 clear=1 at an edge SHALL zero sum, count and sum_ovf, SHALL discard any pending output, and SHALL enter the window-start state of REQ-030, from any state.
REQ-033 clear SHALL take priority over a simultaneous input transfer (no input accepted) and a simultaneous output transfer; that output is still counted as consumed by the consumer.
REQ-034 With DEPTH=1, every nonzero-window sum SHALL carry sum_last=1.

Reset
REQ-035 rst_n=0 SHALL immediately force sum=0, count=0 and sum_ovf=0, independent of clk.
REQ-036 rst_n=0 SHALL force state EMIT_INIT if EMIT_ZERO=1, otherwise WAIT_IN.
REQ-037 Reset values SHALL be in_ready=0, sum_valid=1, sum_data=0 (EMIT_ZERO=1); or in_ready=1, sum_valid=0 (EMIT_ZERO=0).
REQ-038 Deassertion of rst_n SHALL take effect at the first rising clk edge after release; assertion mid-transfer SHALL abort it with no partial update.

Verification
REQ-039 Defaults, sum_ready=1, inputs 3 then 4 -> outputs 0, 3, 7 (last=1), then 0 again.
REQ-040 WIDTH=8, SATURATE=0, DEPTH=2, inputs 200 then 100 -> outputs 200 (ovf=0), 44 (ovf=1, last=1); next window 0 with ovf=0.
REQ-041 SATURATE=1, inputs 200, 100, DEPTH=3, third input 5 -> outputs 200, 255 (ovf=1), 255 (ovf=1, last=1).
REQ-042 sum_ready=0 for 5 cycles after input 9 -> sum_data stays 9, in_ready stays 0, no second input accepted.
REQ-043 clear with in_valid=1 in WAIT_IN after sum 7 -> input not accepted, next output is 0, count restarts.
REQ-044 rst_n pulled low between clk edges in EMIT -> sum_valid and sum_data reflect reset values before the next edge.

Source files
------------

// File: rtl/windowed_accumulator_if.sv
// ============================================================================
// Module      : windowed_accumulator_if
// Description : Operand-in / sum-out handshake bundle for windowed_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface windowed_accumulator_if #(
    parameter int WIDTH    = 8,
    parameter int IN_WIDTH = 8
);
    logic [IN_WIDTH-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    sum_data;
    logic                sum_valid;
    logic                sum_ready;
    logic                sum_last;
    logic                sum_ovf;

    modport master (
        output in_data, in_valid, sum_ready,
        input  in_ready, sum_data, sum_valid, sum_last, sum_ovf
    );

    modport slave (
        input  in_data, in_valid, sum_ready,
        output in_ready, sum_data, sum_valid, sum_last, sum_ovf
    );
endinterface

`default_nettype wire

// File: rtl/windowed_accumulator.sv
// ============================================================================
// Module      : windowed_accumulator
// Description : Accumulates DEPTH operands per window, emitting each running sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module windowed_accumulator #(
    parameter int WIDTH     = 8,
    parameter int IN_WIDTH  = 8,
    parameter int DEPTH     = 2,
    parameter int SATURATE  = 0,
    parameter int EMIT_ZERO = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    windowed_accumulator_if.slave   bus
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        EMIT_INIT = 2'd0,
        WAIT_IN   = 2'd1,
        EMIT      = 2'd2
    } state_t;

    localparam state_t c_start_state = (EMIT_ZERO != 0) ? EMIT_INIT : WAIT_IN;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sum;
    logic [c_cnt_w-1:0] r_count;
    logic               r_ovf;

    logic [WIDTH:0]     w_in_ext;
    logic [WIDTH:0]     w_sum_ext;
    logic               w_carry;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_in_ready;
    logic               w_sum_valid;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_at_depth;

    assign w_in_ext   = {{(WIDTH + 1 - IN_WIDTH){1'b0}}, bus.in_data};
    assign w_sum_ext  = {1'b0, r_sum} + w_in_ext;
    assign w_carry    = w_sum_ext[WIDTH];
    assign w_sum_next = (w_carry && (SATURATE != 0)) ? {WIDTH{1'b1}} : w_sum_ext[WIDTH-1:0];

    assign w_in_ready  = (r_state == WAIT_IN) && !clear;
    assign w_sum_valid = (r_state == EMIT_INIT) || (r_state == EMIT);
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_out_fire  = w_sum_valid && bus.sum_ready;
    assign w_at_depth  = (r_count == c_depth);

    // Sum, count and overflow are always zero in EMIT_INIT, so they drive the bus directly.
    assign bus.in_ready  = w_in_ready;
    assign bus.sum_valid = w_sum_valid;
    assign bus.sum_data  = r_sum;
    assign bus.sum_last  = (r_state == EMIT) && w_at_depth;
    assign bus.sum_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_start_state;
            r_sum   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= c_start_state;
            r_sum   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                EMIT_INIT: begin
                    if (w_out_fire) begin
                        r_state <= WAIT_IN;
                    end
                end
                WAIT_IN: begin
                    if (w_in_fire) begin
                        r_sum   <= w_sum_next;
                        r_count <= r_count + c_cnt_w'(1);
                        r_ovf   <= r_ovf | w_carry;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_out_fire) begin
                        if (w_at_depth) begin
                            r_sum   <= '0;
                            r_count <= '0;
                            r_ovf   <= 1'b0;
                            r_state <= c_start_state;
                        end else begin
                            r_state <= WAIT_IN;
                        end
                    end
                end
                default: begin
                    r_state <= c_start_state;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
